// File: rtl/psum_collector_pkg.sv
// Shared types for the psum collection path: operating modes, pipeline
// stages, the psum packet carried from the PE array, and ofmap sizes.

`ifndef L1_OFMAP_SIZE
`define L1_OFMAP_SIZE 16
`endif
`ifndef L2_OFMAP_SIZE
`define L2_OFMAP_SIZE 8
`endif
`ifndef L3_OFMAP_SIZE
`define L3_OFMAP_SIZE 4
`endif

package psum_collector_pkg;

    localparam int PSUM_PKT_W = 16;

    typedef enum logic [1:0] {
        MODE1,
        MODE2,
        MODE3,
        MODE4
    } OP_MODE;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CONV,
        DRAIN
    } OP_STAGE;

    typedef struct packed {
        logic [PSUM_PKT_W-1:0] psum;
        logic                  valid;
        logic [1:0]            filter_idx;
    } PSUM_PACKET;

    // Collector is either accepting psums or parked after the last one.
    typedef enum logic {
        ST_COLLECT,
        ST_DONE
    } collect_state_t;

endpackage

// File: rtl/psum_collector_if.sv
// Valid/ack psum handshake between the PE array bottom row (master)
// and the psum collector (slave).

interface psum_collector_if;
    import psum_collector_pkg::*;

    PSUM_PACKET psum_in;
    logic       psum_ack;

    modport master (output psum_in, input psum_ack);
    modport slave  (input psum_in, output psum_ack);

endinterface

// File: rtl/psum_collector_quant.sv
// Combinational psum quantiser: optional ReLU, arithmetic right shift,
// then saturation into the signed OUT_W range.

module psum_quant #(
    parameter int PSUM_W = 16,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0
) (
    input  logic signed [PSUM_W-1:0] psum,
    input  logic                     relu_en,
    output logic        [OUT_W-1:0]  q
);

    // Saturation thresholds expressed at psum width so the compare is signed
    // and exact; the minimum is the bitwise complement of the maximum.
    localparam logic signed [PSUM_W-1:0] OUT_MAX = PSUM_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [PSUM_W-1:0] OUT_MIN = ~OUT_MAX;
    localparam logic        [OUT_W-1:0]  Q_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic        [OUT_W-1:0]  Q_MIN   = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [PSUM_W-1:0] rectified;
    logic signed [PSUM_W-1:0] shifted;

    // ReLU happens before the shift so negative values never round toward -1.
    always_comb begin
        rectified = psum;
        if (relu_en && psum[PSUM_W-1]) begin
            rectified = '0;
        end
        shifted = rectified >>> SHIFT;
        if (shifted > OUT_MAX) begin
            q = Q_MAX;
        end else if (shifted < OUT_MIN) begin
            q = Q_MIN;
        end else begin
            q = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/psum_collector.sv
// Receives psums from the PE array bottom row in (psum_idx, filter_idx)
// order, quantises each one and writes it into the ofmap buffer at
// psum_idx*4+filter_idx. Pulses conv_done once the current mode's ofmap
// has been fully written.

module psum_collector
    import psum_collector_pkg::*;
#(
    parameter int PSUM_W  = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT   = 0,
    parameter int ADDR_W  = 8,
    parameter int L1_SIZE = `L1_OFMAP_SIZE,
    parameter int L2_SIZE = `L2_OFMAP_SIZE,
    parameter int L3_SIZE = `L3_OFMAP_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    psum_collector_if.slave   psum_bus,
    input  OP_MODE            mode_in,
    input  logic              change_mode,
    input  logic              conv_continue,
    input  OP_STAGE           op_stage_in,
    input  logic              relu_en,
    input  logic              buf_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [OUT_W-1:0]  wr_data,
    output logic              conv_done,
    output logic              idx_err
);

    localparam int PIDX_W = ADDR_W - 2;

    OP_MODE               cur_mode;
    collect_state_t       state_q;
    collect_state_t       state_d;
    logic [PIDX_W-1:0]    psum_idx;
    logic [1:0]           filter_idx;
    logic [PIDX_W-1:0]    last_idx;
    logic                 clear;
    logic                 ack;
    logic                 is_last;
    logic                 last_fire;
    logic [OUT_W-1:0]     quant_data;

    assign clear             = change_mode | conv_continue;
    assign is_last           = (filter_idx == 2'd3) && (psum_idx == last_idx);
    assign psum_bus.psum_ack = ack;

    psum_quant #(
        .PSUM_W (PSUM_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT)
    ) u_quant (
        .psum    (psum_bus.psum_in.psum),
        .relu_en (relu_en),
        .q       (quant_data)
    );

    // Last psum index of the ofmap for the mode currently loaded.
    always_comb begin
        last_idx = PIDX_W'(L3_SIZE - 1);
        case (cur_mode)
            MODE1, MODE2: last_idx = PIDX_W'(L1_SIZE - 1);
            MODE3:        last_idx = PIDX_W'(L2_SIZE - 1);
            default:      last_idx = PIDX_W'(L3_SIZE - 1);
        endcase
    end

    // Accept decision and collect/done transitions; a clear or reset cycle
    // never acks so a stray packet cannot slip in while counters drop.
    always_comb begin
        state_d = state_q;
        ack     = 1'b0;
        if (!rst && !clear) begin
            case (state_q)
                ST_COLLECT: begin
                    ack = psum_bus.psum_in.valid & buf_ready & (op_stage_in == CONV);
                    if (ack && is_last) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    ack = 1'b0;
                end
            endcase
        end
        if (clear) begin
            state_d = ST_COLLECT;
        end
    end

    // Collector state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode register, only loaded on an explicit mode change.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_mode <= MODE1;
        end else if (change_mode) begin
            cur_mode <= mode_in;
        end
    end

    // Position counters: filter index wraps every four psums and carries into psum_idx.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            psum_idx   <= '0;
            filter_idx <= '0;
        end else if (ack) begin
            filter_idx <= filter_idx + 2'd1;
            if (filter_idx == 2'd3) begin
                psum_idx <= psum_idx + PIDX_W'(1);
            end
        end
    end

    // Sticky flag for packets whose filter index disagrees with our count.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx_err <= 1'b0;
        end else if (ack && (psum_bus.psum_in.filter_idx != filter_idx)) begin
            idx_err <= 1'b1;
        end
    end

    // conv_done trails the final write by one cycle and is dropped by a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_fire <= 1'b0;
            conv_done <= 1'b0;
        end else begin
            last_fire <= ack & is_last & ~clear;
            conv_done <= last_fire & ~clear;
        end
    end

    // Registered buffer write; address and data hold when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= ack;
            if (ack) begin
                wr_addr <= {psum_idx, filter_idx};
                wr_data <= quant_data;
            end
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Directed self-checking bench for psum_collector with small ofmap sizes.

module tb_psum_collector;
    import psum_collector_pkg::*;

    localparam int ADDR_W = 8;
    localparam int OUT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    OP_MODE            mode_in;
    logic              change_mode;
    logic              conv_continue;
    OP_STAGE           op_stage_in;
    logic              relu_en;
    logic              buf_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [OUT_W-1:0]  wr_data;
    logic              conv_done;
    logic              idx_err;

    int checks = 0;
    int errors = 0;

    psum_collector_if bus ();

    psum_collector #(
        .PSUM_W  (16),
        .OUT_W   (OUT_W),
        .SHIFT   (2),
        .ADDR_W  (ADDR_W),
        .L1_SIZE (2),
        .L2_SIZE (3),
        .L3_SIZE (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .psum_bus      (bus),
        .mode_in       (mode_in),
        .change_mode   (change_mode),
        .conv_continue (conv_continue),
        .op_stage_in   (op_stage_in),
        .relu_en       (relu_en),
        .buf_ready     (buf_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .conv_done     (conv_done),
        .idx_err       (idx_err)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive the psum packet and handshake inputs, then let combinational ack settle.
    task automatic applyStimulus(input logic v, input logic [15:0] psum, input logic [1:0] fidx,
                                 input logic ready, input OP_STAGE stage);
        bus.psum_in.valid      = v;
        bus.psum_in.psum       = psum;
        bus.psum_in.filter_idx = fidx;
        buf_ready              = ready;
        op_stage_in            = stage;
        #1;
    endtask

    // One accepted packet and the write it produces a cycle later.
    task automatic sendOne(input string pfx, input logic [15:0] psum, input logic [1:0] fidx,
                           input logic [7:0] exp_addr, input logic [7:0] exp_data, input logic exp_err);
        applyStimulus(1'b1, psum, fidx, 1'b1, CONV);
        checkOutput({pfx, "_ack"}, 32'(bus.psum_ack), 32'd1);
        cycle();
        checkOutput({pfx, "_wr_en"}, 32'(wr_en), 32'd1);
        checkOutput({pfx, "_wr_addr"}, 32'(wr_addr), 32'(exp_addr));
        checkOutput({pfx, "_wr_data"}, 32'(wr_data), 32'(exp_data));
        checkOutput({pfx, "_conv_done"}, 32'(conv_done), 32'd0);
        checkOutput({pfx, "_idx_err"}, 32'(idx_err), 32'(exp_err));
    endtask

    // Valid packet that must not be accepted; write strobe low, address held.
    task automatic stallStep(input string pfx, input logic ready, input OP_STAGE stage,
                             input logic [7:0] exp_addr, input logic exp_cd);
        applyStimulus(1'b1, 16'h0, 2'd0, ready, stage);
        checkOutput({pfx, "_ack_low"}, 32'(bus.psum_ack), 32'd0);
        cycle();
        checkOutput({pfx, "_wr_en_low"}, 32'(wr_en), 32'd0);
        checkOutput({pfx, "_addr_hold"}, 32'(wr_addr), 32'(exp_addr));
        checkOutput({pfx, "_conv_done"}, 32'(conv_done), 32'(exp_cd));
    endtask

    // One clear cycle with a valid packet present; clear must win over ack.
    task automatic clearStep(input string pfx, input logic cm, input logic cc, input OP_MODE m);
        mode_in       = m;
        change_mode   = cm;
        conv_continue = cc;
        applyStimulus(1'b1, 16'h0, 2'd0, 1'b1, CONV);
        checkOutput({pfx, "_clr_ack"}, 32'(bus.psum_ack), 32'd0);
        cycle();
        change_mode   = 1'b0;
        conv_continue = 1'b0;
        checkOutput({pfx, "_clr_wr_en"}, 32'(wr_en), 32'd0);
        checkOutput({pfx, "_clr_idx_err"}, 32'(idx_err), 32'd0);
        checkOutput({pfx, "_clr_conv_done"}, 32'(conv_done), 32'd0);
    endtask

    // Directed sequence covering reset, full ofmaps, stalls, quantisation and clears.
    initial begin
        rst           = 1'b1;
        mode_in       = MODE1;
        change_mode   = 1'b0;
        conv_continue = 1'b0;
        relu_en       = 1'b0;
        bus.psum_in   = '0;
        buf_ready     = 1'b0;
        op_stage_in   = IDLE;

        // Reset state, with a valid packet waiting
        applyStimulus(1'b1, 16'd5, 2'd0, 1'b1, CONV);
        cycle();
        cycle();
        checkOutput("rst_ack", 32'(bus.psum_ack), 32'd0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
        checkOutput("rst_conv_done", 32'(conv_done), 32'd0);
        checkOutput("rst_idx_err", 32'(idx_err), 32'd0);
        rst = 1'b0;

        // Test 1: MODE1, 8 psums back to back, psum=k -> data k>>>2
        for (int k = 0; k < 8; k++) begin
            sendOne("t1", 16'(k), 2'(k % 4), 8'(k), 8'(k >> 2), 1'b0);
        end
        stallStep("t1_done", 1'b1, CONV, 8'd7, 1'b1);
        stallStep("t1_after", 1'b1, CONV, 8'd7, 1'b0);

        // Test 2: MODE3 with buf_ready alternating 1,0; 12 writes, no gaps or dups
        clearStep("t2", 1'b1, 1'b0, MODE3);
        for (int k = 0; k < 12; k++) begin
            sendOne("t2", 16'(k * 4), 2'(k % 4), 8'(k), 8'(k), 1'b0);
            stallStep("t2_stall", 1'b0, CONV, 8'(k), (k == 11));
        end
        stallStep("t2_held", 1'b1, CONV, 8'd11, 1'b0);

        // Test 3: SHIFT=2 saturation, without then with ReLU
        clearStep("t3", 1'b0, 1'b1, MODE1);
        relu_en = 1'b0;
        sendOne("t3_pos_sat", 16'd600, 2'd0, 8'd0, 8'h7F, 1'b0);
        sendOne("t3_neg_sat", 16'hFDA8, 2'd1, 8'd1, 8'h80, 1'b0);
        sendOne("t3_neg4", 16'hFFFC, 2'd2, 8'd2, 8'hFF, 1'b0);
        sendOne("t3_pos7", 16'd7, 2'd3, 8'd3, 8'h01, 1'b0);
        relu_en = 1'b1;
        sendOne("t3r_pos_sat", 16'd600, 2'd0, 8'd4, 8'h7F, 1'b0);
        sendOne("t3r_neg_sat", 16'hFDA8, 2'd1, 8'd5, 8'h00, 1'b0);
        sendOne("t3r_neg4", 16'hFFFC, 2'd2, 8'd6, 8'h00, 1'b0);
        sendOne("t3r_pos7", 16'd7, 2'd3, 8'd7, 8'h01, 1'b0);
        relu_en = 1'b0;

        // Test 4: wrong filter_idx sets sticky idx_err, written at internal address
        clearStep("t4", 1'b0, 1'b1, MODE1);
        sendOne("t4_bad", 16'd8, 2'd2, 8'd0, 8'd2, 1'b1);
        sendOne("t4_sticky", 16'd4, 2'd1, 8'd1, 8'd1, 1'b1);
        clearStep("t4_cc", 1'b0, 1'b1, MODE1);

        // Test 5: change_mode+conv_continue together reload MODE1; clear after 5 acks
        clearStep("t5_both", 1'b1, 1'b1, MODE1);
        for (int k = 0; k < 5; k++) begin
            sendOne("t5_pre", 16'(k * 4), 2'(k % 4), 8'(k), 8'(k), 1'b0);
        end
        clearStep("t5_cc", 1'b0, 1'b1, MODE1);
        stallStep("t5_no_done", 1'b0, CONV, 8'd4, 1'b0);
        for (int k = 0; k < 8; k++) begin
            sendOne("t5_post", 16'(k * 4), 2'(k % 4), 8'(k), 8'(k), 1'b0);
        end
        stallStep("t5_done", 1'b1, CONV, 8'd7, 1'b1);

        // Test 6: reset mid-ofmap in MODE3 restores MODE1 and all outputs
        clearStep("t6", 1'b1, 1'b0, MODE3);
        sendOne("t6_pre0", 16'd4, 2'd0, 8'd0, 8'd1, 1'b0);
        sendOne("t6_pre1", 16'd8, 2'd3, 8'd1, 8'd2, 1'b1);
        sendOne("t6_pre2", 16'd12, 2'd2, 8'd2, 8'd3, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b1, 16'd40, 2'd3, 1'b1, CONV);
        checkOutput("t6_rst_ack", 32'(bus.psum_ack), 32'd0);
        cycle();
        checkOutput("t6_rst_ack2", 32'(bus.psum_ack), 32'd0);
        checkOutput("t6_rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("t6_rst_wr_data", 32'(wr_data), 32'd0);
        checkOutput("t6_rst_conv_done", 32'(conv_done), 32'd0);
        checkOutput("t6_rst_idx_err", 32'(idx_err), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                stallStep("t6_pause", 1'b1, IDLE, 8'd1, 1'b0);
            end
            sendOne("t6_post", 16'(k * 4), 2'(k % 4), 8'(k), 8'(k), 1'b0);
        end
        stallStep("t6_done", 1'b1, CONV, 8'd7, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
